prbs_lane_checker: RTL and testbench
====================================

# prbs_lane_checker

Behavioural/synthesizable PRBS checker for a single differential serial lane, one bit per `clock` rising edge. It sits at the receive end of a simulated link, downstream of the delay line and error injector. It self-synchronizes to an incoming PRBS7/15/31 stream, declares lock, then counts received bits and bit errors so that a bench can compare them against the injector's `errors` count. It detects loss of lock from a windowed error density and re-acquires automatically.

## Interface
- `prbs`, 7, sequence select: 7 (x^7+x^6+1), 15 (x^15+x^14+1), 31 (x^31+x^28+1); any other value is a fatal elaboration error.
- `lock_count`, 16, consecutive correct predictions required to enter LOCKED (1..255).
- `window`, 1024, bits per loss-of-lock evaluation window (2..65535).
- `loss_thresh`, 64, errors within one window that force re-search (1..window).
- `clock`  in  1  bit-rate clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_p`  in  1  lane, positive leg.
- `in_n`  in  1  lane, negative leg.
- `stop`  in  1  freezes `bits`/`errors` (and `invalid`); the FSM keeps running.
- `locked`  out  1  high while in LOCKED.
- `bits`  out  64  bits checked while locked.
- `errors`  out  64  mismatches while locked.
- `invalid`  out  32  count of symbols with `in_p == in_n` (see Configuration).

## Operation
- Symbol: `rx_bit = in_p`. A symbol is invalid when `in_p == in_n`. An invalid symbol always compares as a mismatch.
- Predictor: `prbs`-bit shift register `sr`. `pred = sr[prbs-1] ^ sr[tap-1]`, where tap is 6/14/28.
- FSM states:
  - SEARCH: shift `rx_bit` into `sr`. After `prbs` bits, go to VERIFY with `match_cnt = 0`.
  - VERIFY: compare `rx_bit` with `pred`, then shift `rx_bit` into `sr` (self-synchronous).
    - Mismatch or `sr == 0`: `match_cnt = 0`, stay in VERIFY.
    - Match: increment `match_cnt`. When it reaches `lock_count`, go to LOCKED with window counters cleared.
  - LOCKED: compare `rx_bit` with `pred`, then shift `pred` (not `rx_bit`) into `sr`. The LFSR free-runs, so one channel error produces exactly one counted error.
    - Each bit: `bits++`. On mismatch: `errors++` and `win_err++`.
    - When `win_err` reaches `loss_thresh`, go to SEARCH. The bit/error counts stop after that bit.
    - When `win_bits` reaches `window - 1`, both window counters clear on the next bit.
- Window edge case: an error on the last bit of a window counts toward that window, and the threshold check includes it. The window then restarts at 0/0.
- `bits`, `errors`, and `invalid` saturate at all-ones and never wrap.
- `stop = 1`: counters hold their values; the FSM, `sr`, and window counters still update.
- Reset mid-operation: the next edge returns everything to reset state regardless of FSM state. Counters clear.
- Counters are not cleared by loss of lock; only `reset` clears them.

## Timing
- Reset values: `locked = 0`, `bits = 0`, `errors = 0`, `invalid = 0`, FSM = SEARCH, `sr = 0`, `match_cnt = 0`, `win_bits = 0`, `win_err = 0`.
- `in_p`/`in_n` are registered at edge E0. The comparison happens, and counters/FSM update, at E1. Counter latency is 2 edges from input change.
- Clean stream starting at the first edge after reset deasserts: `locked` rises after edge `1 + prbs + lock_count` (24 for defaults).
- `locked` falls at the same edge that increments `errors` to the threshold-hitting value.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `PRBS_CHECKER_INVALID_CNT_EN` defined: `invalid` increments (saturating, gated by `stop`) on every invalid symbol in any FSM state.
- Macro not defined: `invalid` is constant 0 and its counter logic is not compiled in. Invalid symbols are still treated as mismatches.

## Test plan
- Clean PRBS7 after reset, defaults -> `locked` rises after edge 24; after 1000 further bits, `bits = 1000` and `errors = 0`.
- Locked, single bit inverted on both legs -> `errors = 1` (not 3); `locked` stays high.
- Locked, 64 consecutive inverted bits -> `locked` falls on the 64th, `errors = 64`; after a clean stream resumes, relock in `prbs + lock_count` bits and `errors` stays at 64.
- Locked, `stop = 1` for 100 bits with 5 injected errors -> `bits`/`errors` unchanged during the stop interval, `locked` stays high.
- Constant `in_p = 0`, `in_n = 1` for 500 bits -> `locked` never asserts (`sr == 0` guard).
- With `PRBS_CHECKER_INVALID_CNT_EN`, locked, drive `in_p = in_n = 1` for 3 bits -> `invalid = 3`, `errors = 3`; without the macro, `invalid = 0`.

Source files
------------

// File: rtl/prbs_lane_checker_if.sv
// Lane bundle between a PRBS source/bench (master) and prbs_lane_checker (slave):
// differential lane legs and stop in, lock status and counters out.
interface prbs_lane_checker_if;
  logic        in_p;
  logic        in_n;
  logic        stop;
  logic        locked;
  logic [63:0] bits;
  logic [63:0] errors;
  logic [31:0] invalid;

  modport master (output in_p, in_n, stop, input locked, bits, errors, invalid);
  modport slave  (input in_p, in_n, stop, output locked, bits, errors, invalid);
endinterface

// File: rtl/prbs_lane_checker.sv
// Self-synchronizing PRBS7/15/31 lane checker with windowed loss-of-lock detection.
// Define PRBS_CHECKER_INVALID_CNT_EN to build the invalid-symbol counter.
//
// state     | meaning
// st_search | fill the predictor with received bits
// st_verify | self-synchronous checking, counting consecutive matches
// st_locked | free-running LFSR, counting bits/errors and window error density
module prbs_lane_checker #(
  parameter int prbs        = 7,
  parameter int lock_count  = 16,
  parameter int window      = 1024,
  parameter int loss_thresh = 64
) (
  input logic           clock,
  input logic           reset,
  prbs_lane_checker_if.slave lane
);

  localparam int tap = (prbs == 7) ? 6 : (prbs == 15) ? 14 : 28;

  if (!(prbs == 7 || prbs == 15 || prbs == 31)) begin : g_bad_prbs
    $fatal(1, "prbs_lane_checker: prbs must be 7, 15 or 31");
  end

  typedef enum logic [1:0] {st_search, st_verify, st_locked} state_t;

  state_t            state;
  logic              rx_p;
  logic              rx_n;
  logic              rx_vld;
  logic [prbs-1:0]   sr;
  logic [4:0]        search_cnt;
  logic [7:0]        match_cnt;
  logic [15:0]       win_bits;
  logic [15:0]       win_err;
  logic              locked_q;
  logic [63:0]       bits_q;
  logic [63:0]       errors_q;

  logic              pred;
  logic              miss;
  logic [15:0]       win_err_nxt;

  assign pred        = sr[prbs-1] ^ sr[tap-1];
  // an invalid symbol is a mismatch whatever in_p happens to be
  assign miss        = (rx_p != pred) || (rx_p == rx_n);
  assign win_err_nxt = win_err + {15'd0, miss};

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_p       <= 1'b0;
      rx_n       <= 1'b1;
      rx_vld     <= 1'b0;
      state      <= st_search;
      sr         <= '0;
      search_cnt <= '0;
      match_cnt  <= '0;
      win_bits   <= '0;
      win_err    <= '0;
      locked_q   <= 1'b0;
      bits_q     <= '0;
      errors_q   <= '0;
    end else begin
      rx_p   <= lane.in_p;
      rx_n   <= lane.in_n;
      rx_vld <= 1'b1;
      if (rx_vld) begin
        unique case (state)
          st_search: begin
            sr <= {sr[prbs-2:0], rx_p};
            if (search_cnt == 5'(prbs - 1)) begin
              state      <= st_verify;
              search_cnt <= '0;
              match_cnt  <= '0;
            end else begin
              search_cnt <= search_cnt + 5'd1;
            end
          end
          st_verify: begin
            sr <= {sr[prbs-2:0], rx_p};
            if (miss || sr == '0) begin
              match_cnt <= '0;
            end else if (match_cnt + 8'd1 == 8'(lock_count)) begin
              state     <= st_locked;
              locked_q  <= 1'b1;
              match_cnt <= '0;
              win_bits  <= '0;
              win_err   <= '0;
            end else begin
              match_cnt <= match_cnt + 8'd1;
            end
          end
          st_locked: begin
            // feed back the prediction so a channel error is counted once
            sr <= {sr[prbs-2:0], pred};
            if (!lane.stop) begin
              if (bits_q != '1) bits_q <= bits_q + 64'd1;
              if (miss && errors_q != '1) errors_q <= errors_q + 64'd1;
            end
            if (win_err_nxt == 16'(loss_thresh)) begin
              state      <= st_search;
              locked_q   <= 1'b0;
              search_cnt <= '0;
            end
            if (win_bits == 16'(window - 1)) begin
              win_bits <= '0;
              win_err  <= '0;
            end else begin
              win_bits <= win_bits + 16'd1;
              win_err  <= win_err_nxt;
            end
          end
          default: state <= st_search;
        endcase
      end
    end
  end

  assign lane.locked = locked_q;
  assign lane.bits   = bits_q;
  assign lane.errors = errors_q;

`ifdef PRBS_CHECKER_INVALID_CNT_EN
  logic [31:0] invalid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      invalid_q <= '0;
    end else if (rx_vld && rx_p == rx_n && !lane.stop && invalid_q != '1) begin
      invalid_q <= invalid_q + 32'd1;
    end
  end

  assign lane.invalid = invalid_q;
`else
  assign lane.invalid = '0;
`endif

endmodule

// File: tb/tb_prbs_lane_checker.sv
// Bench for prbs_lane_checker (default parameters, PRBS7): directed table, hand
// sequences for lock/loss/stop/invalid corners, and random stimulus against a history model.
module tb_prbs_lane_checker;
  localparam int P   = 7;
  localparam int T   = 6;
  localparam int LC  = 16;
  localparam int WIN = 1024;
  localparam int TH  = 64;
`ifdef PRBS_CHECKER_INVALID_CNT_EN
  localparam bit inv_en = 1'b1;
`else
  localparam bit inv_en = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  prbs_lane_checker_if lane ();
  prbs_lane_checker dut (.clock(clock), .reset(reset), .lane(lane.slave));

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_model = 1'b0;
  logic [6:0] gen = 7'h7f;

  // reference: mode 0 filling, 1 verifying, 2 locked; history index 0 is newest
  int          m_mode, m_scnt, m_match, m_wb, m_we;
  bit          m_hist[$];
  bit          m_have, m_qp, m_qn, m_locked;
  logic [63:0] m_bits, m_err;
  logic [31:0] m_inv;

  typedef struct {
    int          n_flip;
    int          n_clean;
    bit          stp;
    bit          exp_locked;
    logic [63:0] exp_bits;
    logic [63:0] exp_err;
  } row_t;
  row_t rows[9];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void hist_push(bit b);
    m_hist.push_front(b);
    void'(m_hist.pop_back());
  endfunction

  task automatic model_edge();
    bit rx, bad, pred, miss, zero;
    if (reset) begin
      m_mode = 0; m_scnt = 0; m_match = 0; m_wb = 0; m_we = 0;
      m_have = 0; m_locked = 0; m_bits = '0; m_err = '0; m_inv = '0;
      m_hist.delete();
      repeat (P) m_hist.push_back(1'b0);
      return;
    end
    if (m_have) begin
      rx   = m_qp;
      bad  = (m_qp == m_qn);
      pred = m_hist[P-1] ^ m_hist[T-1];
      miss = bad || (rx != pred);
      zero = 1'b1;
      foreach (m_hist[i]) if (m_hist[i]) zero = 1'b0;
      if (m_mode == 0) begin
        hist_push(rx);
        m_scnt++;
        if (m_scnt == P) begin m_mode = 1; m_match = 0; end
      end else if (m_mode == 1) begin
        hist_push(rx);
        if (miss || zero) m_match = 0;
        else begin
          m_match++;
          if (m_match == LC) begin m_mode = 2; m_locked = 1; m_wb = 0; m_we = 0; end
        end
      end else begin
        hist_push(pred);
        if (!lane.stop) begin
          if (m_bits != '1) m_bits++;
          if (miss && m_err != '1) m_err++;
        end
        if (miss) m_we++;
        if (m_we == TH) begin
          m_mode = 0; m_locked = 0; m_scnt = 0;
        end else begin
          m_wb++;
          if (m_wb == WIN) begin m_wb = 0; m_we = 0; end
        end
      end
      if (inv_en && bad && !lane.stop && m_inv != '1) m_inv++;
    end
    m_qp = lane.in_p; m_qn = lane.in_n; m_have = 1;
  endtask

  task automatic sym(bit p, bit n, bit s);
    lane.in_p = p; lane.in_n = n; lane.stop = s;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    if (cmp_model) begin
      check("model_locked", {63'd0, lane.locked}, {63'd0, m_locked});
      check("model_bits", lane.bits, m_bits);
      check("model_errors", lane.errors, m_err);
      check("model_invalid", {32'd0, lane.invalid}, {32'd0, m_inv});
    end
  endtask

  function automatic bit next_bit();
    bit b;
    b = gen[6] ^ gen[5];
    gen = {gen[5:0], b};
    return b;
  endfunction

  task automatic tx(bit flip, bit s);
    bit b;
    b = next_bit() ^ flip;
    sym(b, ~b, s);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    gen = 7'h7f;
    sym(1'b0, 1'b1, 1'b0);
    sym(1'b0, 1'b1, 1'b0);
    reset = 1'b0;
  endtask

  task automatic lock_up();
    do_reset();
    repeat (24) tx(1'b0, 1'b0);
  endtask

  initial begin
    bit seen_lock;
    int rate, inv_rate;
    bit s;
    lane.in_p = 1'b0; lane.in_n = 1'b1; lane.stop = 1'b0;

    rows[0] = '{0, 100, 0, 1, 100, 0};
    rows[1] = '{1, 9, 0, 1, 110, 1};
    rows[2] = '{3, 7, 0, 1, 120, 4};
    rows[3] = '{2, 8, 1, 1, 120, 4};
    rows[4] = '{0, 10, 0, 1, 130, 4};
    rows[5] = '{58, 1, 0, 0, 189, 62};
    rows[6] = '{0, 22, 0, 0, 189, 62};
    rows[7] = '{0, 1, 0, 1, 189, 62};
    rows[8] = '{0, 5, 0, 1, 194, 62};

    do_reset();
    check("reset_locked", {63'd0, lane.locked}, 64'd0);
    check("reset_bits", lane.bits, 64'd0);
    check("reset_errors", lane.errors, 64'd0);
    check("reset_invalid", {32'd0, lane.invalid}, 64'd0);
    repeat (23) tx(1'b0, 1'b0);
    check("lock_early", {63'd0, lane.locked}, 64'd0);
    tx(1'b0, 1'b0);
    check("lock_edge24", {63'd0, lane.locked}, 64'd1);
    check("lock_bits0", lane.bits, 64'd0);

    foreach (rows[r]) begin
      repeat (rows[r].n_flip) tx(1'b1, rows[r].stp);
      repeat (rows[r].n_clean) tx(1'b0, rows[r].stp);
      check($sformatf("row%0d_locked", r), {63'd0, lane.locked}, {63'd0, rows[r].exp_locked});
      check($sformatf("row%0d_bits", r), lane.bits, rows[r].exp_bits);
      check($sformatf("row%0d_errors", r), lane.errors, rows[r].exp_err);
    end

    lock_up();
    repeat (1000) tx(1'b0, 1'b0);
    check("clean1000_bits", lane.bits, 64'd1000);
    check("clean1000_errors", lane.errors, 64'd0);
    tx(1'b1, 1'b0);
    repeat (2) tx(1'b0, 1'b0);
    check("single_err", lane.errors, 64'd1);
    check("single_locked", {63'd0, lane.locked}, 64'd1);

    lock_up();
    repeat (10) tx(1'b0, 1'b0);
    repeat (64) tx(1'b1, 1'b0);
    check("burst63_locked", {63'd0, lane.locked}, 64'd1);
    check("burst63_errors", lane.errors, 64'd63);
    tx(1'b0, 1'b0);
    check("burst64_locked", {63'd0, lane.locked}, 64'd0);
    check("burst64_errors", lane.errors, 64'd64);
    check("burst64_bits", lane.bits, 64'd75);
    repeat (22) tx(1'b0, 1'b0);
    check("relock_early", {63'd0, lane.locked}, 64'd0);
    tx(1'b0, 1'b0);
    check("relock_edge", {63'd0, lane.locked}, 64'd1);
    check("relock_errors", lane.errors, 64'd64);
    for (int i = 0; i < 100; i++) tx(i % 20 == 10, 1'b1);
    check("stop_bits", lane.bits, 64'd75);
    check("stop_errors", lane.errors, 64'd64);
    check("stop_locked", {63'd0, lane.locked}, 64'd1);

    do_reset();
    seen_lock = 1'b0;
    repeat (500) begin
      sym(1'b0, 1'b1, 1'b0);
      seen_lock |= lane.locked;
    end
    check("zero_never_lock", {63'd0, seen_lock}, 64'd0);
    check("zero_bits", lane.bits, 64'd0);

    lock_up();
    repeat (3) begin
      void'(next_bit());
      sym(1'b1, 1'b1, 1'b0);
    end
    tx(1'b0, 1'b0);
    check("inv_errors", lane.errors, 64'd3);
    check("inv_count", {32'd0, lane.invalid}, inv_en ? 64'd3 : 64'd0);
    check("inv_locked", {63'd0, lane.locked}, 64'd1);

    do_reset();
    cmp_model = 1'b1;
    rate = 0; inv_rate = 0; s = 1'b0;
    for (int c = 0; c < 9000; c++) begin
      bit b;
      if (c % 600 == 0) begin
        case ($urandom_range(0, 3))
          0: rate = 0;
          1: rate = 300;
          2: rate = 17;
          default: rate = 9;
        endcase
        inv_rate = ($urandom_range(0, 1) == 1) ? 150 : 0;
      end
      if ($urandom_range(0, 29) == 0) s = ~s;
      if ($urandom_range(0, 2999) == 0) gen = 7'($urandom_range(1, 127));
      reset = (c == 5000);
      b = next_bit();
      if (rate != 0 && $urandom_range(1, rate) == 1) b = ~b;
      if (inv_rate != 0 && $urandom_range(1, inv_rate) == 1) sym(b, b, s);
      else sym(b, ~b, s);
    end
    reset = 1'b0;
    cmp_model = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
